post_adder_preg: RTL and testbench
==================================

// Module: post_adder_preg
// PURPOSE
//  Second-stage adder/subtracter of the DSP slice, directly downstream of X_MUX, Y_MUX and Z_MUX.
//  Combines the three 48-bit mux outputs with a carry-in under ALU_MODE control.
//  Holds the result in the P register; P feeds back to the X/Z mux P inputs for accumulation.
//  Also produces carry-out, pattern detect, and overflow/underflow flags.
// PARAMETERS
//  PREG              1             1: P and flags registered; 0: combinational (flags still valid)
//  ALUMODEREG        1             1: ALU_MODE registered (CECTRL); 0: used directly
//  CARRYINREG        1             1: CARRY_IN registered (CECARRYIN); 0: used directly
//  PATTERN           48'h0         compare value for pattern detect
//  MASK              48'h3FFF_FFFF_FFFF  1 = bit ignored in compare
//  AUTORESET_PATDET  0             1: clear P the cycle after registered PATTERN_DETECT=1
// PORTS
//  CLK               in   1   clock, rising edge
//  RST               in   1   asynchronous active-high reset, all registers
//  CEP               in   1   clock enable: P, CARRY_OUT, flag registers
//  CECTRL            in   1   clock enable: ALU_MODE register
//  CECARRYIN         in   1   clock enable: CARRY_IN register
//  X_MUX_OUT         in   48  X operand (signed)
//  Y_MUX_OUT         in   48  Y operand (signed)
//  Z_MUX_OUT         in   48  Z operand (signed)
//  ALU_MODE          in   4   operation select
//  CARRY_IN          in   1   carry-in
//  P                 out  48  result
//  CARRY_OUT         out  1   carry-out of final 48-bit add
//  PATTERN_DETECT    out  1   (P ^ PATTERN) & ~MASK == 0
//  PATTERN_B_DETECT  out  1   (P ^ ~PATTERN) & ~MASK == 0
//  OVERFLOW          out  1   detect -> no detect transition
//  UNDERFLOW         out  1   detect_b -> no detect transition
// BEHAVIOUR
//  - Reset: all outputs 0; ALU_MODE_r = 4'b0000; CARRY_IN_r = 0; pattern-history regs = 0.
//  - RST dominates every CE. CE=0 holds the register contents.
//  - XY = (X + Y + CIN) mod 2^48.
//  - ALU_MODE results; CARRY_OUT = bit 48 of the 49-bit adder:
//      0000: Z + XY
//      0011: Z - XY
//      0001: XY - Z - 1          (~Z + XY)
//      0010: ~(Z + XY)
//      other: result 0, CARRY_OUT 0
//  - Subtract is two's complement: Z + ~XY + 1; CARRY_OUT = 1 means no borrow.
//  - Wrap-around: result truncated to 48 bits, no saturation.
//  - Latency, PREG=1: operands -> P in 1 cycle.
//  - Latency, ALUMODEREG/CARRYINREG=1: control applies to operands presented one cycle later.
//  - Pattern flags are computed from the next-P value and registered with P (same CEP).
//  - OVERFLOW(n)  = PD(n-1) & ~PD(n) & ~PBD(n).
//  - UNDERFLOW(n) = PBD(n-1) & ~PD(n) & ~PBD(n).
//  - History advances only when CEP=1. When PREG=0, OVERFLOW/UNDERFLOW are tied 0.
//  - Autoreset: if registered PATTERN_DETECT=1 and CEP=1, next P=0.
//    Flags recompute from 0; this takes priority over the new sum. Ignored when PREG=0.
//  - Reset mid-accumulation: P and history clear at once; the first post-reset cycle has no OVERFLOW.
// STRUCTURE
//  - dsp_pkg: ALU_MODE localparams (ALU_ADD, ALU_ZSUB, ALU_SUBZ, ALU_NOT), DATA_W = 48.
//  - Sub-module dsp_pattern_detect: combinational PD/PBD compare of the next-P value.
//  - Top: control regs, 49-bit adder, P/flag regs, autoreset mux.
// TESTING
//  - Add: X=5, Y=7, Z=100, CIN=1, mode 0000 -> next-cycle P=113, CARRY_OUT=0.
//  - Subtract: Z=10, X=3, Y=0, mode 0011 -> P=7, CARRY_OUT=1.
//    Z=3, X=10 -> P=48'hFFFF_FFFF_FFF9, CARRY_OUT=0.
//  - Accumulate wrap: Z=P, X=1, start P=48'hFFFF_FFFF_FFFF -> P=0, CARRY_OUT=1.
//    Default MASK: PD=1 then 0 at P=48'h8000_0000_0000, giving OVERFLOW=1 one cycle.
//  - CE/reset: CEP=0 for 3 cycles holds P; RST asserted mid-stream between edges
//    -> P=0 and flags=0 immediately, with no clock edge needed.
//  - Autoreset=1, PATTERN=48'd20, MASK=0, accumulate +5 from 0 -> P 5,10,15,20,0,5; PD=1 only at 20.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP slice datapath: operand width and ALU_MODE encodings.
package dsp_pkg;

  localparam int unsigned DATA_W = 48;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUBZ = 4'b0001,
    ALU_NOT  = 4'b0010,
    ALU_ZSUB = 4'b0011
  } alu_mode_e;

endpackage

// File: rtl/dsp_pattern_detect.sv
// Combinational pattern / inverted-pattern compare of a P value; MASK bits set to 1 are ignored.
module dsp_pattern_detect
  import dsp_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = '0,
  parameter logic [DATA_W-1:0] MASK    = 48'h3FFF_FFFF_FFFF
) (
  input  logic [DATA_W-1:0] value,
  output logic              pd,
  output logic              pbd
);

  always_comb begin
    pd  = ((value ^ PATTERN) & ~MASK) == '0;
    pbd = ((value ^ ~PATTERN) & ~MASK) == '0;
  end

endmodule

// File: rtl/post_adder_preg.sv
// Second-stage adder/subtracter of the DSP slice: control registers, 49-bit adder,
// P/flag registers with pattern history and optional autoreset on pattern detect.
module post_adder_preg
  import dsp_pkg::*;
#(
  parameter int unsigned       PREG             = 1,
  parameter int unsigned       ALUMODEREG       = 1,
  parameter int unsigned       CARRYINREG       = 1,
  parameter logic [DATA_W-1:0] PATTERN          = 48'h0,
  parameter logic [DATA_W-1:0] MASK             = 48'h3FFF_FFFF_FFFF,
  parameter int unsigned       AUTORESET_PATDET = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CEP,
  input  logic              CECTRL,
  input  logic              CECARRYIN,
  input  logic [DATA_W-1:0] X_MUX_OUT,
  input  logic [DATA_W-1:0] Y_MUX_OUT,
  input  logic [DATA_W-1:0] Z_MUX_OUT,
  input  logic [3:0]        ALU_MODE,
  input  logic              CARRY_IN,
  output logic [DATA_W-1:0] P,
  output logic              CARRY_OUT,
  output logic              PATTERN_DETECT,
  output logic              PATTERN_B_DETECT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  logic [3:0]        mode_r;
  logic              cin_r;
  logic [3:0]        mode_eff;
  logic              cin_eff;
  logic [DATA_W-1:0] xy;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_co;
  logic              ar_hit;
  logic [DATA_W-1:0] nxt_p;
  logic              nxt_co;
  logic              pd_n;
  logic              pbd_n;

  logic [DATA_W-1:0] p_r;
  logic              co_r;
  logic              pd_r;
  logic              pbd_r;
  logic              of_r;
  logic              uf_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_r <= ALU_ADD;
      cin_r  <= 1'b0;
    end else begin
      if (CECTRL)    mode_r <= ALU_MODE;
      if (CECARRYIN) cin_r  <= CARRY_IN;
    end
  end

  assign mode_eff = (ALUMODEREG != 0) ? mode_r : ALU_MODE;
  assign cin_eff  = (CARRYINREG != 0) ? cin_r  : CARRY_IN;
  assign xy       = X_MUX_OUT + Y_MUX_OUT + {{(DATA_W-1){1'b0}}, cin_eff};

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_co  = 1'b0;
    case (mode_eff)
      ALU_ADD: begin
        sum     = {1'b0, Z_MUX_OUT} + {1'b0, xy};
        alu_res = sum[DATA_W-1:0];
        alu_co  = sum[DATA_W];
      end
      ALU_ZSUB: begin
        sum     = {1'b0, Z_MUX_OUT} + {1'b0, ~xy} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[DATA_W-1:0];
        alu_co  = sum[DATA_W];
      end
      ALU_SUBZ: begin
        sum     = {1'b0, ~Z_MUX_OUT} + {1'b0, xy};
        alu_res = sum[DATA_W-1:0];
        alu_co  = sum[DATA_W];
      end
      ALU_NOT: begin
        sum     = {1'b0, Z_MUX_OUT} + {1'b0, xy};
        alu_res = ~sum[DATA_W-1:0];
        alu_co  = sum[DATA_W];
      end
      default: begin
        sum     = '0;
        alu_res = '0;
        alu_co  = 1'b0;
      end
    endcase
  end

  // Autoreset only exists with a registered P; it overrides the fresh sum.
  assign ar_hit = (AUTORESET_PATDET != 0) && (PREG != 0) && pd_r;
  assign nxt_p  = ar_hit ? '0   : alu_res;
  assign nxt_co = ar_hit ? 1'b0 : alu_co;

  dsp_pattern_detect #(
    .PATTERN (PATTERN),
    .MASK    (MASK)
  ) u_patdet (
    .value (nxt_p),
    .pd    (pd_n),
    .pbd   (pbd_n)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_r   <= '0;
      co_r  <= 1'b0;
      pd_r  <= 1'b0;
      pbd_r <= 1'b0;
      of_r  <= 1'b0;
      uf_r  <= 1'b0;
    end else if (CEP) begin
      p_r   <= nxt_p;
      co_r  <= nxt_co;
      pd_r  <= pd_n;
      pbd_r <= pbd_n;
      of_r  <= pd_r & ~pd_n & ~pbd_n;
      uf_r  <= pbd_r & ~pd_n & ~pbd_n;
    end
  end

  assign P                = (PREG != 0) ? p_r   : nxt_p;
  assign CARRY_OUT        = (PREG != 0) ? co_r  : nxt_co;
  assign PATTERN_DETECT   = (PREG != 0) ? pd_r  : pd_n;
  assign PATTERN_B_DETECT = (PREG != 0) ? pbd_r : pbd_n;
  assign OVERFLOW         = (PREG != 0) ? of_r  : 1'b0;
  assign UNDERFLOW        = (PREG != 0) ? uf_r  : 1'b0;

endmodule

// File: tb/tb_post_adder_preg.sv
// Self-checking bench for post_adder_preg: directed scenarios plus randomized stimulus
// against an arithmetic reference model; dut0 uses defaults, dut1 autoresets on P==20.
module tb_post_adder_preg;

  localparam logic [47:0] PAT0  = 48'h0;
  localparam logic [47:0] MASK0 = 48'h3FFF_FFFF_FFFF;
  localparam logic [47:0] PAT1  = 48'd20;
  localparam logic [47:0] MASK1 = 48'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cep, cectrl, cecarryin;
  logic [47:0] x_in, y_in, z_in;
  logic        fb;
  logic [3:0]  alu_mode;
  logic        carry_in;

  logic [47:0] p0, p1, z0, z1;
  logic        co0, pd0, pbd0, of0, uf0;
  logic        co1, pd1, pbd1, of1, uf1;

  int vectors = 0;
  int errors  = 0;

  logic [47:0] m_p   [2];
  logic        m_co  [2];
  logic        m_pd  [2];
  logic        m_pbd [2];
  logic        m_of  [2];
  logic        m_uf  [2];
  logic [3:0]  m_mode;
  logic        m_cin;

  assign z0 = fb ? p0 : z_in;
  assign z1 = fb ? p1 : z_in;

  always #5 clk = ~clk;

  post_adder_preg #(
    .PREG(1), .ALUMODEREG(1), .CARRYINREG(1),
    .PATTERN(PAT0), .MASK(MASK0), .AUTORESET_PATDET(0)
  ) dut0 (
    .CLK(clk), .RST(rst), .CEP(cep), .CECTRL(cectrl), .CECARRYIN(cecarryin),
    .X_MUX_OUT(x_in), .Y_MUX_OUT(y_in), .Z_MUX_OUT(z0),
    .ALU_MODE(alu_mode), .CARRY_IN(carry_in),
    .P(p0), .CARRY_OUT(co0), .PATTERN_DETECT(pd0), .PATTERN_B_DETECT(pbd0),
    .OVERFLOW(of0), .UNDERFLOW(uf0)
  );

  post_adder_preg #(
    .PREG(1), .ALUMODEREG(1), .CARRYINREG(1),
    .PATTERN(PAT1), .MASK(MASK1), .AUTORESET_PATDET(1)
  ) dut1 (
    .CLK(clk), .RST(rst), .CEP(cep), .CECTRL(cectrl), .CECARRYIN(cecarryin),
    .X_MUX_OUT(x_in), .Y_MUX_OUT(y_in), .Z_MUX_OUT(z1),
    .ALU_MODE(alu_mode), .CARRY_IN(carry_in),
    .P(p1), .CARRY_OUT(co1), .PATTERN_DETECT(pd1), .PATTERN_B_DETECT(pbd1),
    .OVERFLOW(of1), .UNDERFLOW(uf1)
  );

  // Returns {carry_out, result} from the arithmetic meaning of each mode.
  function automatic logic [48:0] ref_alu(input logic [3:0] m, input logic [47:0] x,
                                          input logic [47:0] y, input logic [47:0] z,
                                          input logic c);
    logic [47:0] xy;
    logic [48:0] s;
    xy = x + y + 48'(c);
    case (m)
      4'd0:    s = 49'(z) + 49'(xy);
      4'd3:    s = {(z >= xy), 48'(z - xy)};
      4'd1:    s = {(xy > z), 48'(xy - z - 48'd1)};
      4'd2:    begin s = 49'(z) + 49'(xy); s[47:0] = ~s[47:0]; end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic match(input logic [47:0] v, input logic [47:0] pat,
                                 input logic [47:0] mask);
    return ((v ^ pat) & ~mask) == 48'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p[k] = '0; m_co[k] = 1'b0; m_pd[k] = 1'b0;
      m_pbd[k] = 1'b0; m_of[k] = 1'b0; m_uf[k] = 1'b0;
    end
    m_mode = 4'd0;
    m_cin  = 1'b0;
  endtask

  // Advance one clock: predict from pre-edge inputs, commit at the edge, settle 1 time unit.
  task automatic tick();
    logic [47:0] np [2];
    logic nco [2], npd [2], npbd [2], nof [2], nuf [2];
    logic [48:0] r;
    logic [47:0] pat, mask, zz;
    for (int k = 0; k < 2; k++) begin
      pat  = (k == 1) ? PAT1  : PAT0;
      mask = (k == 1) ? MASK1 : MASK0;
      zz   = fb ? m_p[k] : z_in;
      r    = ref_alu(m_mode, x_in, y_in, zz, m_cin);
      if (k == 1 && m_pd[1]) begin
        np[k] = '0; nco[k] = 1'b0;
      end else begin
        np[k] = r[47:0]; nco[k] = r[48];
      end
      npd[k]  = match(np[k], pat, mask);
      npbd[k] = match(np[k], ~pat, mask);
      nof[k]  = m_pd[k]  & ~npd[k] & ~npbd[k];
      nuf[k]  = m_pbd[k] & ~npd[k] & ~npbd[k];
    end
    @(posedge clk);
    if (!rst) begin
      if (cep) begin
        for (int k = 0; k < 2; k++) begin
          m_p[k] = np[k]; m_co[k] = nco[k]; m_pd[k] = npd[k];
          m_pbd[k] = npbd[k]; m_of[k] = nof[k]; m_uf[k] = nuf[k];
        end
      end
      if (cectrl)    m_mode = alu_mode;
      if (cecarryin) m_cin  = carry_in;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cep = 1'b1; cectrl = 1'b1; cecarryin = 1'b1;
    x_in = '0; y_in = '0; z_in = '0; fb = 1'b0; alu_mode = 4'd0; carry_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({p0, co0, pd0, pbd0, of0, uf0, p1, co1, pd1, pbd1, of1, uf1} !== '0) begin
      errors++;
      $display("FAIL reset: got p0=%h flags0=%b p1=%h flags1=%b, required all zero",
               p0, {co0, pd0, pbd0, of0, uf0}, p1, {co1, pd1, pbd1, of1, uf1});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    alu_mode = 4'd0; carry_in = 1'b1;
    tick();
    x_in = 48'd5; y_in = 48'd7; z_in = 48'd100;
    tick();
    vectors++;
    if (p0 !== 48'd113 || co0 !== 1'b0 || p0 !== m_p[0]) begin
      errors++;
      $display("FAIL add: got P=%0d CO=%b, required P=113 CO=0", p0, co0);
    end
  endtask

  task automatic test_sub();
    alu_mode = 4'd3; carry_in = 1'b0;
    tick();
    z_in = 48'd10; x_in = 48'd3; y_in = 48'd0;
    tick();
    vectors++;
    if (p0 !== 48'd7 || co0 !== 1'b1) begin
      errors++;
      $display("FAIL sub_pos: got P=%h CO=%b, required P=7 CO=1", p0, co0);
    end
    z_in = 48'd3; x_in = 48'd10;
    tick();
    vectors++;
    if (p0 !== 48'hFFFF_FFFF_FFF9 || co0 !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: got P=%h CO=%b, required P=fffffffffff9 CO=0", p0, co0);
    end
  endtask

  task automatic test_accum_overflow();
    alu_mode = 4'd0; carry_in = 1'b0;
    tick();
    x_in = 48'hFFFF_FFFF_FFFF; y_in = '0; z_in = '0;
    tick();
    vectors++;
    if (p0 !== 48'hFFFF_FFFF_FFFF || pd0 !== 1'b0 || pbd0 !== 1'b1) begin
      errors++;
      $display("FAIL acc_load: got P=%h PD=%b PBD=%b, required P=ffffffffffff PD=0 PBD=1",
               p0, pd0, pbd0);
    end
    fb = 1'b1; x_in = 48'd1;
    tick();
    vectors++;
    if (p0 !== 48'h0 || co0 !== 1'b1 || pd0 !== 1'b1 || uf0 !== 1'b0) begin
      errors++;
      $display("FAIL acc_wrap: got P=%h CO=%b PD=%b UF=%b, required P=0 CO=1 PD=1 UF=0",
               p0, co0, pd0, uf0);
    end
    x_in = 48'h8000_0000_0000;
    tick();
    vectors++;
    if (p0 !== 48'h8000_0000_0000 || pd0 !== 1'b0 || of0 !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got P=%h PD=%b OF=%b, required P=800000000000 PD=0 OF=1",
               p0, pd0, of0);
    end
    x_in = '0;
    tick();
    vectors++;
    if (of0 !== 1'b0 || p0 !== 48'h8000_0000_0000) begin
      errors++;
      $display("FAIL overflow_pulse: got OF=%b P=%h, required OF=0 P=800000000000", of0, p0);
    end
    fb = 1'b0;
  endtask

  task automatic test_ce_hold();
    logic [47:0] held;
    held = m_p[0];
    cep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_in = 48'd123 + 48'(i); z_in = 48'd999;
      tick();
      vectors++;
      if (p0 !== held || p0 !== 48'h8000_0000_0000) begin
        errors++;
        $display("FAIL ce_hold[%0d]: got P=%h, required P=%h", i, p0, held);
      end
    end
    cep = 1'b1;
  endtask

  task automatic test_reset_mid();
    fb = 1'b1; x_in = 48'd1; y_in = '0; alu_mode = 4'd0; carry_in = 1'b0;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({p0, co0, pd0, pbd0, of0, uf0} !== '0) begin
      errors++;
      $display("FAIL reset_async: got P=%h flags=%b, required all zero without a clock edge",
               p0, {co0, pd0, pbd0, of0, uf0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    vectors++;
    if (of0 !== 1'b0 || uf0 !== 1'b0 || p0 !== 48'd1) begin
      errors++;
      $display("FAIL reset_first_cycle: got P=%h OF=%b UF=%b, required P=1 OF=0 UF=0",
               p0, of0, uf0);
    end
    fb = 1'b0;
  endtask

  task automatic test_autoreset();
    logic [47:0] exp_p  [6];
    logic        exp_pd [6];
    exp_p  = '{48'd5, 48'd10, 48'd15, 48'd20, 48'd0, 48'd5};
    exp_pd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fb = 1'b1; x_in = 48'd5; y_in = '0; alu_mode = 4'd0; carry_in = 1'b0;
    cep = 1'b1; cectrl = 1'b1; cecarryin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (p1 !== exp_p[i] || pd1 !== exp_pd[i] || p1 !== m_p[1]) begin
        errors++;
        $display("FAIL autoreset[%0d]: got P=%0d PD=%b, required P=%0d PD=%b",
                 i, p1, pd1, exp_p[i], exp_pd[i]);
      end
    end
    fb = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      x_in      = 48'({$urandom(), $urandom()});
      y_in      = ($urandom_range(0, 3) == 0) ? 48'({$urandom(), $urandom()}) : 48'($urandom_range(0, 8));
      z_in      = 48'({$urandom(), $urandom()});
      fb        = ($urandom_range(0, 2) == 0);
      alu_mode  = 4'($urandom_range(0, 5));
      carry_in  = 1'($urandom_range(0, 1));
      cep       = ($urandom_range(0, 4) != 0);
      cectrl    = ($urandom_range(0, 3) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if ({p0, co0, pd0, pbd0, of0, uf0} !== {m_p[0], m_co[0], m_pd[0], m_pbd[0], m_of[0], m_uf[0]}) begin
        errors++;
        $display("FAIL rand_dut0[%0d]: got P=%h co/pd/pbd/of/uf=%b, required P=%h %b",
                 i, p0, {co0, pd0, pbd0, of0, uf0},
                 m_p[0], {m_co[0], m_pd[0], m_pbd[0], m_of[0], m_uf[0]});
      end
      vectors++;
      if ({p1, co1, pd1, pbd1, of1, uf1} !== {m_p[1], m_co[1], m_pd[1], m_pbd[1], m_of[1], m_uf[1]}) begin
        errors++;
        $display("FAIL rand_dut1[%0d]: got P=%h co/pd/pbd/of/uf=%b, required P=%h %b",
                 i, p1, {co1, pd1, pbd1, of1, uf1},
                 m_p[1], {m_co[1], m_pd[1], m_pbd[1], m_of[1], m_uf[1]});
      end
    end
    cep = 1'b1; cectrl = 1'b1; cecarryin = 1'b1; fb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_accum_overflow();
    test_ce_hold();
    test_reset_mid();
    test_autoreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
